class_argmax: RTL and testbench
===============================

CLASS_ARGMAX -- requirements
Module: class_argmax

Interface
REQ-001 Parameter NUM_CLASSES, 10, number of output-layer neuron scores per frame (2..16).
REQ-002 Parameter W, 16, score width, signed Q8.8 two's complement.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data carries one neuron dot-product result.
REQ-006 in_data  input  W  signed Q8.8 dot-product result, in class order 0..NUM_CLASSES-1.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 biases  input  NUM_CLASSES*W  per-class signed Q8.8 bias; class k occupies bits [k*W+W-1 : k*W]; held stable for a whole frame.
REQ-009 flush  input  1  discard the partial frame and return to idle.
REQ-010 out_valid  output  1  one-cycle pulse; class_out and max_score are valid.
REQ-011 class_out  output  4  index of the winning class.
REQ-012 max_score  output  W  biased, saturated score of the winning class.
REQ-013 busy  output  1  high while a frame is partially collected.

Function
REQ-014 States: IDLE (no samples held), ACCUM (1..NUM_CLASSES-1 samples held), DONE (result presented).
REQ-015 A sample is accepted on a cycle with in_valid=1 and in_ready=1; in_ready=1 in IDLE and ACCUM and 0 in DONE.
REQ-016 Accepted sample k: sum = sign-extended (W+1)-bit in_data + biases[k]; score = 0x7FFF if sum > 0x7FFF, 0x8000 if sum < -0x8000, otherwise sum[W-1:0].
REQ-017 Sample index k comes from an internal counter: 0 on entry to IDLE, +1 per accepted sample.
REQ-018 Sample 0 unconditionally loads the running max (score, index 0).
REQ-019 Each later sample replaces the running max only if its score is strictly greater (signed); ties keep the lower index.
REQ-020 IDLE -> ACCUM on acceptance of sample 0 when NUM_CLASSES > 1.
REQ-021 ACCUM -> DONE on acceptance of sample NUM_CLASSES-1; that sample takes part in the comparison.
REQ-022 In DONE: out_valid=1 for exactly one cycle, class_out/max_score show the final running max, next state is IDLE.
REQ-023 Latency: out_valid rises the cycle after the last sample is accepted.
REQ-024 Throughput: one sample per cycle in IDLE/ACCUM; one bubble (the DONE cycle) per frame.
REQ-025 class_out and max_score hold their last result until the next out_valid; they are not guaranteed meaningful while out_valid=0.
REQ-026 busy=1 exactly in ACCUM.
REQ-027 flush=1 in any state: next state IDLE, counter 0, running max discarded; a sample presented in the same cycle is not incorporated; a DONE-cycle out_valid already driven completes.
REQ-028 No input sample is lost or double-counted across an ACCUM->DONE->IDLE sequence if in_valid is held high.

Reset
REQ-029 While reset=1 on a rising edge: state IDLE, counter 0, running max cleared.
REQ-030 Outputs after reset: out_valid=0, class_out=0, max_score=0, busy=0, in_ready=1.
REQ-031 reset takes priority over flush and in_valid; a frame interrupted by reset is discarded with no out_valid.

Verification
REQ-032 Zero biases, scores 0x0100,0x0200,...,0x0A00 back to back -> out_valid one cycle after the 10th, class_out=9, max_score=0x0A00.
REQ-033 Scores all 0x0300 except classes 2 and 7 = 0x0500 -> class_out=2 (tie goes to lower index), max_score=0x0500.
REQ-034 in_data=0x7F00 with bias 0x0200 at class 4, others 0 -> score saturates at 0x7FFF, class_out=4; in_data=0x8100 with bias 0xFE00 -> score 0x8000.
REQ-035 All scores negative (0xFF00 down to 0xF600), zero biases -> class_out=0, max_score=0xFF00.
REQ-036 Five samples, then flush, then a full frame with max at class 6 -> single out_valid, class_out=6; repeat using reset instead of flush -> same result, no spurious out_valid.
REQ-037 in_valid held high for 20 samples -> in_ready=0 on the two DONE cycles, two out_valid pulses, second frame uses samples 11-20 only.

Source files
------------

// File: rtl/class_argmax.sv
// Output-layer argmax: biases and saturates each class score as it arrives,
// tracks the running maximum, and pulses the winning class once per frame.
module class_argmax #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned W           = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     in_ready,
  input  logic [NUM_CLASSES*W-1:0] biases,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [3:0]               class_out,
  output logic [W-1:0]             max_score,
  output logic                     busy
);

  localparam logic [3:0]          LastIdx  = 4'(NUM_CLASSES - 1);
  localparam logic signed [W-1:0] ScoreMax = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ScoreMin = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e state_q, state_d;

  logic [3:0]          cnt_q, cnt_d;
  logic signed [W-1:0] run_max_q, run_max_d;
  logic [3:0]          run_idx_q, run_idx_d;
  logic signed [W-1:0] res_score_q, res_score_d;
  logic [3:0]          res_class_q, res_class_d;

  logic                can_take;
  logic                accept;
  logic                last;
  logic [W-1:0]        bias_sel;
  logic [W:0]          sum;
  logic signed [W-1:0] score;
  logic signed [W-1:0] cand_max;
  logic [3:0]          cand_idx;

  // Samples are taken in IDLE and ACCUM; a flush in the same cycle drops the sample.
  assign can_take = (state_q != StDone);
  assign in_ready = can_take;
  assign accept   = in_valid && can_take && !flush;
  assign last     = (cnt_q == LastIdx);

  // Bias for the class currently being received, added at W+1 bits so overflow is visible.
  assign bias_sel = biases[cnt_q*W +: W];
  assign sum      = {in_data[W-1], in_data} + {bias_sel[W-1], bias_sel};

  // Clamp the biased sum to the signed W-bit range.
  always_comb begin
    score = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      score = sum[W] ? ScoreMin : ScoreMax;
    end
  end

  // Running-max candidate: sample 0 always loads; later samples only win if strictly greater.
  always_comb begin
    cand_max = run_max_q;
    cand_idx = run_idx_q;
    if (cnt_q == 4'd0 || score > run_max_q) begin
      cand_max = score;
      cand_idx = cnt_q;
    end
  end

  // Next state and control outputs.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = last ? StDone : StAccum;
      end
      StAccum: begin
        busy = 1'b1;
        if (accept && last) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  // Datapath next state: counter, running max, and the held result.
  always_comb begin
    cnt_d       = cnt_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    res_score_d = res_score_q;
    res_class_d = res_class_q;
    if (flush) begin
      cnt_d     = 4'd0;
      run_max_d = '0;
      run_idx_d = 4'd0;
    end else if (accept) begin
      run_max_d = cand_max;
      run_idx_d = cand_idx;
      if (last) begin
        // Result is captured here so it is stable throughout the DONE cycle and after.
        cnt_d       = 4'd0;
        res_score_d = cand_max;
        res_class_d = cand_idx;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 4'd0;
      run_max_q   <= '0;
      run_idx_q   <= 4'd0;
      res_score_q <= '0;
      res_class_q <= 4'd0;
    end else begin
      cnt_q       <= cnt_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      res_score_q <= res_score_d;
      res_class_q <= res_class_d;
    end
  end

  assign class_out = res_class_q;
  assign max_score = res_score_q;

endmodule

// File: tb/tb_class_argmax.sv
// Scoreboard bench for class_argmax: stimulus pushes expected results, a monitor pops
// and compares on every out_valid pulse.
module tb_class_argmax;

  localparam int N = 10;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [N*W-1:0] biases;
  logic           flush;
  logic           out_valid;
  logic [3:0]     class_out;
  logic [W-1:0]   max_score;
  logic           busy;

  int n_vec  = 0;
  int n_fail = 0;

  logic [19:0] exp_q[$];
  logic [15:0] frame[N];

  class_argmax #(.NUM_CLASSES(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .biases    (biases),
    .flush     (flush),
    .out_valid (out_valid),
    .class_out (class_out),
    .max_score (max_score),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every out_valid must match the oldest pending expectation.
  initial begin
    logic [19:0] e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL spurious_out_valid: got class %0d score %0h, expected no result",
                   class_out, max_score);
        end else begin
          e = exp_q.pop_front();
          check("class_out", {28'd0, class_out}, {28'd0, e[19:16]});
          check("max_score", {16'd0, max_score}, {16'd0, e[15:0]});
        end
      end
    end
  end

  task automatic set_bias(input int k, input logic [15:0] v);
    biases[k*W +: W] = v;
  endtask

  // Drive frame[] back to back, then check latency and the DONE bubble.
  task automatic drive_frame();
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      in_data  = frame[k];
      @(posedge clk); #1;
      if (k == 0) check("busy_after_first", {31'd0, busy}, 32'd1);
    end
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    check("latency_out_valid", {31'd0, out_valid}, 32'd1);
    check("ready_low_in_done", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drive_partial_big();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h7000;
      @(posedge clk); #1;
    end
  endtask

  task automatic load_max6();
    for (int k = 0; k < N; k++) frame[k] = 16'h0100;
    frame[6] = 16'h0600;
  endtask

  initial begin
    logic [15:0] s[20];
    int          idx;
    int          nlow;
    int          cyc;
    logic        rdy;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    flush    = 1'b0;
    biases   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_class_out", {28'd0, class_out}, 32'd0);
    check("rst_max_score", {16'd0, max_score}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Ascending scores: last class wins.
    for (int k = 0; k < N; k++) frame[k] = 16'((k + 1) * 256);
    exp_q.push_back({4'd9, 16'h0A00});
    drive_frame();

    // Tie between classes 2 and 7 goes to the lower index.
    for (int k = 0; k < N; k++) frame[k] = 16'h0300;
    frame[2] = 16'h0500;
    frame[7] = 16'h0500;
    exp_q.push_back({4'd2, 16'h0500});
    drive_frame();

    // Positive saturation at class 4.
    for (int k = 0; k < N; k++) frame[k] = 16'h0000;
    frame[4] = 16'h7F00;
    set_bias(4, 16'h0200);
    exp_q.push_back({4'd4, 16'h7FFF});
    drive_frame();

    // Negative saturation everywhere: all tie at 0x8000, class 0 wins.
    for (int k = 0; k < N; k++) begin
      frame[k] = 16'h8100;
      set_bias(k, 16'hFE00);
    end
    exp_q.push_back({4'd0, 16'h8000});
    drive_frame();
    biases = '0;

    // All negative, descending: class 0 wins.
    for (int k = 0; k < N; k++) frame[k] = 16'(16'hFF00 - k * 256);
    exp_q.push_back({4'd0, 16'hFF00});
    drive_frame();

    // Partial frame, flush with a sample present, then a clean frame.
    drive_partial_big();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h7000;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("busy_after_flush", {31'd0, busy}, 32'd0);
    load_max6();
    exp_q.push_back({4'd6, 16'h0600});
    drive_frame();

    // Same with reset: held result is cleared, frame discarded without a pulse.
    drive_partial_big();
    reset    = 1'b1;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("busy_after_reset", {31'd0, busy}, 32'd0);
    check("class_after_reset", {28'd0, class_out}, 32'd0);
    load_max6();
    exp_q.push_back({4'd6, 16'h0600});
    drive_frame();

    // Continuous stream of 20 samples with in_valid held high.
    for (int i = 0; i < 20; i++) s[i] = 16'h0100;
    s[3]  = 16'h0400;
    s[18] = 16'h0800;
    exp_q.push_back({4'd3, 16'h0400});
    exp_q.push_back({4'd8, 16'h0800});
    idx  = 0;
    nlow = 0;
    cyc  = 0;
    while (idx < 20 && cyc < 40) begin
      in_valid = 1'b1;
      in_data  = s[idx];
      @(negedge clk);
      rdy = in_ready;
      if (!rdy) nlow++;
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    check("stream_all_taken", idx, 20);
    in_data = 16'h7F00;
    @(negedge clk);
    if (!in_ready) nlow++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
    check("stream_ready_low_cycles", nlow, 2);

    // Drain: all expected results must have appeared.
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    check("pending_results", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
